subset_gamma: RTL and testbench

SUBSET_GAMMA -- requirements
Module: subset_gamma

---
 rtl/subset_gamma_pkg.sv | 18 +
 rtl/float_to_uint.sv | 28 ++
 rtl/subset_gamma.sv | 109 ++++++++++
 tb/tb_subset_gamma.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/subset_gamma_pkg.sv
// Shared types and float constants for the subset intensity (gamma) fetch block.
package subset_gamma_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV,
      S_ADDR,
      S_WAIT,
      S_STORE,
      S_DONE
   } state_t;

   localparam logic [31:0] FLT_ZERO   = 32'h0000_0000;
   localparam logic [31:0] FLT_ONE    = 32'h3F80_0000;
   localparam int unsigned FLT_BIAS   = 127;
   localparam int unsigned FLT_MANT_W = 23;

endpackage

// File: rtl/float_to_uint.sv
// Combinational IEEE-754 single to unsigned integer, truncating toward zero.
// ovf flags negative nonzero values and magnitudes of 2^24 and above.
module float_to_uint
   import subset_gamma_pkg::*;
(
   input  logic [31:0] f,
   output logic [31:0] u,
   output logic        ovf
);

   logic [7:0]  expo;
   logic [23:0] sig;
   logic [4:0]  sh;

   always_comb begin
      expo = f[30:23];
      sig  = {1'b1, f[22:0]};
      u    = '0;
      sh   = '0;
      ovf  = (f[31] && (f[30:0] != 31'd0)) || (expo > 8'(FLT_BIAS + FLT_MANT_W));
      // Below the bias the value is a pure fraction and truncates to 0.
      if (expo >= 8'(FLT_BIAS) && expo <= 8'(FLT_BIAS + FLT_MANT_W)) begin
         sh = 5'(8'(FLT_BIAS + FLT_MANT_W) - expo);
         u  = {8'd0, sig >> sh};
      end
   end

endmodule

// File: rtl/subset_gamma.sv
// Fetches one pixel per subset coordinate and returns each intensity as a float.
// Four cycles per slot: CONV, ADDR, WAIT, STORE.
module subset_gamma
   import subset_gamma_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int N_POINTS   = 9
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [32*N_POINTS-1:0]  x,
   input  logic [32*N_POINTS-1:0]  y,
   input  logic                    sub_done,
   output logic [31:0]             img_addr,
   output logic                    img_rd_en,
   input  logic [7:0]              img_data,
   output logic [32*N_POINTS-1:0]  gamma,
   output logic                    range_err,
   output logic                    gamma_done
);

   localparam int KW = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;

   state_t                      state;
   logic [N_POINTS-1:0][31:0]   x_q, y_q;
   logic [KW-1:0]               k;
   logic                        sub_prev, armed, slot_oor;
   logic [7:0]                  pix;

   logic [31:0] xi, yi, addr_nxt, pix_flt;
   logic        x_ovf, y_ovf, conv_oor, start;
   logic [2:0]  msb;
   logic [22:0] pix_man;

   float_to_uint u_fx (.f(x_q[k]), .u(xi), .ovf(x_ovf));
   float_to_uint u_fy (.f(y_q[k]), .u(yi), .ovf(y_ovf));

   // armed is cleared by reset so a level held high through reset cannot start a run.
   assign start    = sub_done & ~sub_prev & armed;
   assign conv_oor = x_ovf | y_ovf | (xi >= 32'(IMG_WIDTH)) | (yi >= 32'(IMG_HEIGHT));
   assign addr_nxt = yi * 32'(IMG_WIDTH) + xi;

   always_comb begin
      msb = '0;
      for (int i = 0; i < 8; i++)
         if (pix[i]) msb = 3'(i);
      pix_man = {15'd0, pix} << (5'd23 - {2'd0, msb});
      pix_flt = (pix == 8'd0) ? FLT_ZERO
                              : {1'b0, 8'(FLT_ONE[30:23] + {5'd0, msb}), pix_man};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         gamma      <= '0;
         gamma_done <= 1'b0;
         range_err  <= 1'b0;
         img_rd_en  <= 1'b0;
         img_addr   <= '0;
         k          <= '0;
         sub_prev   <= 1'b0;
         armed      <= 1'b0;
         slot_oor   <= 1'b0;
         pix        <= '0;
         x_q        <= '0;
         y_q        <= '0;
      end else begin
         sub_prev  <= sub_done;
         if (!sub_done) armed <= 1'b1;
         img_rd_en <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (state == S_DONE) gamma_done <= 1'b1;
               if (start) begin
                  x_q        <= x;
                  y_q        <= y;
                  gamma_done <= 1'b0;
                  range_err  <= 1'b0;
                  k          <= '0;
                  state      <= S_CONV;
               end
            end
            S_CONV: begin
               slot_oor <= conv_oor;
               if (conv_oor) begin
                  range_err <= 1'b1;
               end else begin
                  img_addr  <= addr_nxt;
                  img_rd_en <= 1'b1;
               end
               state <= S_ADDR;
            end
            S_ADDR:  state <= S_WAIT;
            S_WAIT: begin
               pix   <= img_data;
               state <= S_STORE;
            end
            S_STORE: begin
               gamma[32*k +: 32] <= slot_oor ? FLT_ZERO : pix_flt;
               k                 <= k + KW'(1);
               state             <= (k == KW'(N_POINTS - 1)) ? S_DONE : S_CONV;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_subset_gamma.sv
// Self-checking bench for subset_gamma: directed table, reset/restart and glitch
// sequences, then random coordinates against a real-arithmetic reference model.
module tb_subset_gamma;

   localparam int N  = 9;
   localparam int W  = 640;
   localparam int H  = 480;
   localparam int VW = 32 * N;

   logic          clock = 1'b0, reset = 1'b1, sub_done = 1'b0;
   logic [VW-1:0] x = '0, y = '0, gamma;
   logic [31:0]   img_addr;
   logic          img_rd_en, range_err, gamma_done;
   logic [7:0]    img_data = '0;
   logic [7:0]    mem_key = '0;

   subset_gamma #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .N_POINTS(N)) dut (
      .clock(clock), .reset(reset), .x(x), .y(y), .sub_done(sub_done),
      .img_addr(img_addr), .img_rd_en(img_rd_en), .img_data(img_data),
      .gamma(gamma), .range_err(range_err), .gamma_done(gamma_done)
   );

   always #5 clock = ~clock;

   // Memory: data valid one cycle after the strobe, noise otherwise.
   always @(posedge clock)
      img_data <= img_rd_en ? (img_addr[7:0] ^ mem_key) : 8'($urandom);

   logic [31:0] rd_q[$];
   always @(negedge clock)
      if (img_rd_en) rd_q.push_back(img_addr);

   int pass_cnt = 0, tot_cnt = 0;

   logic [VW-1:0] m_gamma;
   logic          m_err;
   logic [31:0]   m_addr[$];

   typedef struct {
      logic [VW-1:0] xv, yv;
      logic [31:0]   g0, g1;
      logic          err;
      int            reads;
      logic [31:0]   addr0;
   } vec_t;
   vec_t tbl[4];

   task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic real pow2(int n);
      real r = 1.0;
      if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
      else        for (int i = 0; i < -n; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real f_mag(logic [31:0] b);
      int e = int'(b[30:23]);
      if (e == 0) return real'(b[22:0]) * pow2(-149);
      return (1.0 + real'(b[22:0]) / 8388608.0) * pow2(e - 127);
   endfunction

   task automatic to_int(input logic [31:0] b, output longint v, output bit bad);
      real mag = f_mag(b);
      bad = (b[30:23] == 8'hFF) || (b[31] && mag != 0.0) || (mag >= 16777216.0);
      v   = bad ? 0 : longint'($floor(mag));
   endtask

   function automatic logic [31:0] u8_flt(int p);
      int e = 0;
      if (p == 0) return 32'h0;
      while ((2 ** (e + 1)) <= p) e++;
      return {1'b0, 8'(127 + e), 23'((p - 2 ** e) * 2 ** (23 - e))};
   endfunction

   task automatic model(input logic [VW-1:0] xv, input logic [VW-1:0] yv);
      longint xi, yi, a;
      bit bx, by;
      m_addr.delete();
      m_err   = 1'b0;
      m_gamma = '0;
      for (int s = 0; s < N; s++) begin
         to_int(xv[32*s +: 32], xi, bx);
         to_int(yv[32*s +: 32], yi, by);
         if (bx || by || xi >= W || yi >= H) m_err = 1'b1;
         else begin
            a = yi * W + xi;
            m_addr.push_back(32'(a));
            m_gamma[32*s +: 32] = u8_flt(int'(8'(a % 256) ^ mem_key));
         end
      end
   endtask

   // One full operation; glitch>0 drops sub_done at that cycle and re-raises it two later.
   task automatic run_op(input logic [VW-1:0] xv, input logic [VW-1:0] yv, input int glitch);
      int n = 0;
      int nrd;
      model(xv, yv);
      @(negedge clock);
      sub_done = 1'b0;
      x = xv;
      y = yv;
      @(negedge clock);
      sub_done = 1'b1;
      rd_q.delete();
      @(posedge clock);
      #1 chk("done_clear", VW'(gamma_done), VW'(0));
      do begin
         @(posedge clock);
         #1 n++;
         if (glitch > 0 && n == glitch)     sub_done = 1'b0;
         if (glitch > 0 && n == glitch + 2) sub_done = 1'b1;
      end while (!gamma_done && n < 200);
      chk("done_cycle", VW'(n), VW'(37));
      chk("gamma", gamma, m_gamma);
      chk("range_err", VW'(range_err), VW'(m_err));
      nrd = rd_q.size();
      chk("read_count", VW'(nrd), VW'(m_addr.size()));
      for (int i = 0; i < nrd && i < m_addr.size(); i++)
         chk("read_addr", VW'(rd_q[i]), VW'(m_addr[i]));
      repeat (5) @(posedge clock);
      #1 chk("done_hold", VW'(gamma_done), VW'(1));
      chk("no_restart", VW'(rd_q.size()), VW'(nrd));
   endtask

   function automatic logic [31:0] rnd_coord(int emax);
      int r = int'($urandom_range(0, 15));
      if (r == 0) return $urandom;
      if (r == 1) return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h0;
      return {1'b0, 8'($urandom_range(118, emax)), 23'($urandom)};
   endfunction

   initial begin
      logic [VW-1:0] xv, yv;
      logic [31:0]   a0;
      tbl[0] = '{{N{32'h4120_0000}}, {N{32'h41A0_0000}}, 32'h4120_0000, 32'h4120_0000, 1'b0, 9, 32'd12810};
      tbl[1] = '{{N{32'h412C_0000}}, {N{32'h41A0_0000}}, 32'h4120_0000, 32'h4120_0000, 1'b0, 9, 32'd12810};
      tbl[2] = '{{{(N-2){32'h4120_0000}}, 32'h437F_0000, 32'h0},
                 {{(N-2){32'h41A0_0000}}, 32'h0, 32'h0},
                 32'h0, 32'h437F_0000, 1'b0, 9, 32'd0};
      tbl[3] = '{{{(N-5){32'h4120_0000}}, 32'hBF80_0000, {4{32'h4120_0000}}},
                 {{(N-6){32'h41A0_0000}}, 32'h43F0_0000, {5{32'h41A0_0000}}},
                 32'h4120_0000, 32'h4120_0000, 1'b1, 7, 32'd12810};

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_gamma", gamma, '0);
      chk("rst_done", VW'(gamma_done), VW'(0));
      chk("rst_err", VW'(range_err), VW'(0));
      chk("rst_rd_en", VW'(img_rd_en), VW'(0));
      chk("rst_addr", VW'(img_addr), VW'(0));
      reset = 1'b0;

      for (int i = 0; i < 4; i++) begin
         mem_key = '0;
         run_op(tbl[i].xv, tbl[i].yv, 0);
         chk("tbl_g0", VW'(gamma[31:0]), VW'(tbl[i].g0));
         chk("tbl_g1", VW'(gamma[63:32]), VW'(tbl[i].g1));
         chk("tbl_err", VW'(range_err), VW'(tbl[i].err));
         chk("tbl_reads", VW'(rd_q.size()), VW'(tbl[i].reads));
         a0 = (rd_q.size() > 0) ? rd_q[0] : 32'hFFFF_FFFF;
         chk("tbl_addr0", VW'(a0), VW'(tbl[i].addr0));
      end

      // Start edge while busy must be ignored.
      run_op(tbl[0].xv, tbl[0].yv, 10);

      // Reset mid-operation with sub_done held high throughout.
      @(negedge clock);
      sub_done = 1'b0;
      x = tbl[0].xv;
      y = tbl[0].yv;
      @(negedge clock);
      sub_done = 1'b1;
      @(posedge clock);
      repeat (20) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("mid_rst_gamma", gamma, '0);
      chk("mid_rst_done", VW'(gamma_done), VW'(0));
      chk("mid_rst_err", VW'(range_err), VW'(0));
      chk("mid_rst_rd_en", VW'(img_rd_en), VW'(0));
      chk("mid_rst_addr", VW'(img_addr), VW'(0));
      @(negedge clock);
      reset = 1'b0;
      rd_q.delete();
      repeat (50) @(posedge clock);
      #1;
      chk("held_no_read", VW'(rd_q.size()), VW'(0));
      chk("held_no_done", VW'(gamma_done), VW'(0));
      run_op(tbl[0].xv, tbl[0].yv, 0);

      for (int t = 0; t < 20; t++) begin
         mem_key = 8'($urandom);
         for (int s = 0; s < N; s++) begin
            xv[32*s +: 32] = rnd_coord(137);
            yv[32*s +: 32] = rnd_coord(136);
         end
         run_op(xv, yv, 0);
      end

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
